// File: rtl/sdram_arbiter.sv
// Arbitrates the SDRAM sequencer between two access ports and auto-refresh; owns the refresh timer and debt counter.
// Optional zero-gap locked back-to-back access under SDRAM_ARB_LOCK_EN. Decision to seq_start is one CLK; grant is held until seq_done.
module sdram_arbiter #(
  parameter int REFRESH_INTERVAL = 390,
  parameter int DEBT_MAX         = 8,
  parameter int DEBT_URGENT      = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       init_done,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  output logic [1:0] gnt,
  output logic       seq_start,
  output logic       seq_refresh,
  output logic       seq_port,
  input  logic       seq_done,
  output logic [3:0] refresh_debt,
  output logic       refresh_ovf
);

  localparam int TW = (REFRESH_INTERVAL > 2) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(REFRESH_INTERVAL - 1);
  localparam logic [3:0]    DEBT_MAX_V   = 4'(DEBT_MAX);
  localparam logic [3:0]    DEBT_URG_V   = 4'(DEBT_URGENT);

  typedef enum logic [1:0] {IDLE, ACCESS, REFRESH} state_t;

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic [3:0]    debt_q, debt_d;
  logic          ovf_q, ovf_d;
  logic          rr_q, rr_vld_q;
  logic [1:0]    gnt_q;
  logic          start_q, refresh_q, port_q;

  logic credit, urgent, want_refresh, want_access, pick_port, issue, lock_go;

  always_comb begin
    credit       = init_done && (timer_q == '0);
    urgent       = (debt_q >= DEBT_URG_V);
    want_refresh = urgent || ((req == 2'b00) && (debt_q != 4'd0));
    want_access  = !urgent && (req != 2'b00);
    issue        = (state_q == IDLE) && init_done && want_refresh;

    // Tie goes to the port that did not win last; before any grant port 0 wins.
    case (req)
      2'b10:   pick_port = 1'b1;
      2'b11:   pick_port = rr_vld_q & ~rr_q;
      default: pick_port = 1'b0;
    endcase

    debt_d = debt_q;
    ovf_d  = ovf_q;
    if (credit && !issue) begin
      if (debt_q == DEBT_MAX_V) ovf_d = 1'b1;
      else                      debt_d = debt_q + 4'd1;
    end else if (issue && !credit) begin
      debt_d = debt_q - 4'd1;
    end
  end

`ifdef SDRAM_ARB_LOCK_EN
  assign lock_go = lock[port_q] && req[port_q] && !urgent;
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign lock_go     = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      timer_q   <= TIMER_RELOAD;
      debt_q    <= 4'd0;
      ovf_q     <= 1'b0;
      rr_q      <= 1'b0;
      rr_vld_q  <= 1'b0;
      gnt_q     <= 2'b00;
      start_q   <= 1'b0;
      refresh_q <= 1'b0;
      port_q    <= 1'b0;
    end else begin
      start_q <= 1'b0;
      debt_q  <= debt_d;
      ovf_q   <= ovf_d;
      if (init_done) timer_q <= credit ? TIMER_RELOAD : timer_q - 1'b1;

      case (state_q)
        IDLE: begin
          if (init_done) begin
            if (want_refresh) begin
              start_q   <= 1'b1;
              refresh_q <= 1'b1;
              gnt_q     <= 2'b00;
              state_q   <= REFRESH;
            end else if (want_access) begin
              start_q   <= 1'b1;
              refresh_q <= 1'b0;
              port_q    <= pick_port;
              gnt_q     <= pick_port ? 2'b10 : 2'b01;
              rr_q      <= pick_port;
              rr_vld_q  <= 1'b1;
              state_q   <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (seq_done) begin
            if (lock_go) begin
              start_q <= 1'b1;
            end else begin
              gnt_q   <= 2'b00;
              state_q <= IDLE;
            end
          end
        end
        REFRESH: begin
          if (seq_done) begin
            refresh_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt          = gnt_q;
  assign seq_start    = start_q;
  assign seq_refresh  = refresh_q;
  assign seq_port     = port_q;
  assign refresh_debt = debt_q;
  assign refresh_ovf  = ovf_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a 16-cycle refresh interval; a simple sequencer
// model answers seq_start with seq_done after a fixed latency when enabled.
module tb_sdram_arbiter;
  localparam int RI = 16;

  logic       CLK = 1'b0;
  logic       RESET, init_done, seq_done;
  logic [1:0] req, lock;
  logic [1:0] gnt;
  logic       seq_start, seq_refresh, seq_port, refresh_ovf;
  logic [3:0] refresh_debt;

  always #5 CLK = ~CLK;

  sdram_arbiter #(.REFRESH_INTERVAL(RI), .DEBT_MAX(8), .DEBT_URGENT(4)) dut (
    .CLK(CLK), .RESET(RESET), .init_done(init_done), .req(req), .lock(lock),
    .gnt(gnt), .seq_start(seq_start), .seq_refresh(seq_refresh), .seq_port(seq_port),
    .seq_done(seq_done), .refresh_debt(refresh_debt), .refresh_ovf(refresh_ovf)
  );

  int errors = 0;
  int checks = 0;
  int cyc, dcnt, lat;
  bit auto_en;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock edge; afterwards outputs are stable and the sequencer model reacts.
  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
    if (auto_en) begin
      seq_done = 1'b0;
      if (seq_start) dcnt = lat;
      else if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) seq_done = 1'b1;
      end
    end
  endtask

  task automatic do_reset(input bit init);
    RESET = 1'b1; req = 2'b00; lock = 2'b00; seq_done = 1'b0;
    auto_en = 1'b0; dcnt = 0; lat = 2; init_done = init;
    repeat (3) step();
    RESET = 1'b0;
    cyc = 0;
  endtask

  int first, second, maxd, bad, n;
  logic [1:0] g [4];
  logic p1;

  initial begin
    cyc = 0;

    // Reset values, then no activity while init_done is low.
    do_reset(1'b0);
    check("rst_gnt", gnt, 0);
    check("rst_start", seq_start, 0);
    check("rst_refresh", seq_refresh, 0);
    check("rst_port", seq_port, 0);
    check("rst_debt", refresh_debt, 0);
    check("rst_ovf", refresh_ovf, 0);
    req = 2'b11; bad = 0;
    repeat (40) begin step(); if (seq_start) bad++; end
    check("noinit_starts", bad, 0);
    check("noinit_debt", refresh_debt, 0);

    // Periodic refresh with no requests.
    do_reset(1'b1);
    auto_en = 1'b1; first = -1; second = -1; maxd = 0; bad = 0;
    repeat (40) begin
      step();
      if (int'(refresh_debt) > maxd) maxd = refresh_debt;
      if (seq_start) begin
        if (!seq_refresh || gnt != 2'b00) bad++;
        if (first < 0) first = cyc;
        else if (second < 0) second = cyc;
      end
    end
    check("ref_first", first, 17);
    check("ref_period", second - first, RI);
    check("ref_qual", bad, 0);
    check("ref_maxdebt", maxd, 1);
    check("ref_enddebt", refresh_debt, 0);

    // Round robin with both ports requesting.
    do_reset(1'b1);
    req = 2'b11; auto_en = 1'b1; n = 0; p1 = 1'b0;
    repeat (16) begin
      step();
      if (seq_start && n < 4) begin
        g[n] = gnt;
        if (n == 1) p1 = seq_port;
        n++;
      end
    end
    check("rr_count", n, 4);
    check("rr_g0", g[0], 1);
    check("rr_g1", g[1], 2);
    check("rr_g2", g[2], 1);
    check("rr_g3", g[3], 2);
    check("rr_port1", p1, 1);

    // Stalled access builds urgent debt; refresh preempts the still-pending request.
    do_reset(1'b1);
    req = 2'b01;
    step();
    check("lat_start", seq_start, 1);
    check("lat_gnt", gnt, 1);
    while (cyc < 66) step();
    check("urg_debt", refresh_debt, 4);
    check("urg_gnt_held", gnt, 1);
    seq_done = 1'b1;
    step();
    seq_done = 1'b0;
    check("urg_done_gnt", gnt, 0);
    step();
    check("urg_ref_start", seq_start, 1);
    check("urg_ref_qual", seq_refresh, 1);
    check("urg_ref_debt", refresh_debt, 3);
    auto_en = 1'b1; dcnt = lat;
    repeat (4) step();
    check("urg_acc_start", seq_start, 1);
    check("urg_acc_qual", seq_refresh, 0);
    check("urg_acc_gnt", gnt, 1);

    // Debt saturation and sticky overflow, then drain.
    do_reset(1'b1);
    req = 2'b01;
    while (cyc < 140) step();
    check("sat_debt140", refresh_debt, 8);
    check("sat_ovf140", refresh_ovf, 0);
    while (cyc < 150) step();
    check("sat_debt150", refresh_debt, 8);
    check("sat_ovf150", refresh_ovf, 1);
    req = 2'b00; seq_done = 1'b1; auto_en = 1'b1; dcnt = 0;
    step();
    step();
    check("drain_start", seq_start, 1);
    check("drain_qual", seq_refresh, 1);
    while (cyc < 190) step();
    check("drain_debt", refresh_debt, 0);
    check("drain_ovf", refresh_ovf, 1);

    // Locked back-to-back access on port 1.
    do_reset(1'b1);
    req = 2'b10; lock = 2'b10; auto_en = 1'b1;
    step();
    check("lk_start1", seq_start, 1);
    check("lk_gnt1", gnt, 2);
    repeat (3) step();
`ifdef SDRAM_ARB_LOCK_EN
    check("lk_done_start", seq_start, 1);
    check("lk_done_gnt", gnt, 2);
    step();
    check("lk_next_start", seq_start, 0);
    check("lk_next_gnt", gnt, 2);
`else
    check("lk_done_start", seq_start, 0);
    check("lk_done_gnt", gnt, 0);
    step();
    check("lk_next_start", seq_start, 1);
    check("lk_next_gnt", gnt, 2);
`endif

    // Reset held 3 cycles in the middle of an access.
    do_reset(1'b1);
    req = 2'b01;
    repeat (3) step();
    check("mid_gnt", gnt, 1);
    RESET = 1'b1; req = 2'b00;
    repeat (3) step();
    RESET = 1'b0;
    check("mid_rst_gnt", gnt, 0);
    check("mid_rst_start", seq_start, 0);
    check("mid_rst_debt", refresh_debt, 0);
    repeat (2) step();
    check("mid_idle_gnt", gnt, 0);
    check("mid_idle_start", seq_start, 0);
    req = 2'b01;
    step();
    check("mid_fresh_start", seq_start, 1);
    check("mid_fresh_gnt", gnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
